// File: rtl/adc_sample_source.sv
// adc_sample_source: paces ECG sampling, runs a 20-bit serial ADC (CONVST + SPI mode 0,
// MSB first) and presents each result as a two's-complement word with a sample strobe.
`timescale 1ns/1ps
module adc_sample_source #(
  parameter int DIV           = 50000,
  parameter int CONV_CYCLES   = 40,
  parameter int SCLK_HALF     = 4,
  parameter int STROBE_CYCLES = 8,
  parameter bit OFFSET_BIN    = 1'b0
) (
  input  logic        qzt_clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        adc_miso,
  output logic        adc_convst,
  output logic        adc_cs_n,
  output logic        adc_sclk,
  output logic [19:0] Vout,
  output logic        clk_out,
  output logic        overrun
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CW = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
  localparam int HW = $clog2(2 * SCLK_HALF);
  localparam int SW = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;

  localparam logic [PW-1:0] PER_LAST  = PW'(DIV - 1);
  localparam logic [CW-1:0] CONV_LAST = CW'(CONV_CYCLES - 1);
  localparam logic [HW-1:0] SUB_LAST  = HW'(2 * SCLK_HALF - 1);
  localparam logic [HW-1:0] SUB_RISE  = HW'(SCLK_HALF - 1);
  localparam logic [SW-1:0] STB_LOAD  = SW'(STROBE_CYCLES - 1);
  // Offset-binary ADCs differ from two's complement only in the sign bit.
  localparam logic [19:0]   VOUT_XOR  = OFFSET_BIN ? 20'h80000 : 20'h00000;

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_READ, S_DONE} state_t;

  state_t        state_q;
  logic [PW-1:0] per_q, per_d;
  logic [CW-1:0] conv_cnt_q;
  logic [HW-1:0] sub_q;
  logic [4:0]    bit_q;
  logic [19:0]   shreg_q;
  logic          convst_q, cs_n_q, sclk_q;
  logic [19:0]   vout_q;
  logic          clk_out_q;
  logic [SW-1:0] stb_q;
  logic          overrun_q;
  logic          tick;

  // Period counter next value: free-running wrap while enabled, parked at 0 otherwise.
  always_comb begin
    per_d = per_q;
    if (!enable)                per_d = '0;
    else if (per_q == PER_LAST) per_d = '0;
    else                        per_d = per_q + PW'(1);
  end

  assign tick = enable && (per_q == PER_LAST);

  // Sample-period counter register; never stalls on converter state.
  always_ff @(posedge qzt_clk or posedge rst) begin
    if (rst) per_q <= '0;
    else     per_q <= per_d;
  end

  // Conversion sequencer, SPI shifter, output word, strobe timer and overrun flag.
  always_ff @(posedge qzt_clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      conv_cnt_q <= '0;
      sub_q      <= '0;
      bit_q      <= '0;
      shreg_q    <= '0;
      convst_q   <= 1'b0;
      cs_n_q     <= 1'b1;
      sclk_q     <= 1'b0;
      vout_q     <= '0;
      clk_out_q  <= 1'b0;
      stb_q      <= '0;
      overrun_q  <= 1'b0;
    end else begin
      // A tick that finds the converter busy is dropped and remembered.
      if (tick && (state_q != S_IDLE)) overrun_q <= 1'b1;

      // Strobe width is timed independently so it can overlap the next conversion.
      if (clk_out_q) begin
        if (stb_q == '0) clk_out_q <= 1'b0;
        else             stb_q     <= stb_q - SW'(1);
      end

      case (state_q)
        S_IDLE: begin
          if (tick) begin
            state_q    <= S_CONV;
            convst_q   <= 1'b1;
            conv_cnt_q <= '0;
          end
        end
        S_CONV: begin
          convst_q <= 1'b0;
          if (conv_cnt_q == CONV_LAST) begin
            state_q <= S_READ;
            cs_n_q  <= 1'b0;
            sclk_q  <= 1'b0;
            sub_q   <= '0;
            bit_q   <= '0;
          end else begin
            conv_cnt_q <= conv_cnt_q + CW'(1);
          end
        end
        S_READ: begin
          if (sub_q == SUB_LAST) begin
            sclk_q <= 1'b0;
            sub_q  <= '0;
            if (bit_q == 5'd19) begin
              state_q <= S_DONE;
              cs_n_q  <= 1'b1;
            end else begin
              bit_q <= bit_q + 5'd1;
            end
          end else begin
            sub_q <= sub_q + HW'(1);
            // End of the low phase: raise SCLK and capture the bit the ADC is presenting.
            if (sub_q == SUB_RISE) begin
              sclk_q  <= 1'b1;
              shreg_q <= {shreg_q[18:0], adc_miso};
            end
          end
        end
        S_DONE: begin
          cs_n_q    <= 1'b1;
          sclk_q    <= 1'b0;
          vout_q    <= shreg_q ^ VOUT_XOR;
          clk_out_q <= 1'b1;
          stb_q     <= STB_LOAD;
          state_q   <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign adc_convst = convst_q;
  assign adc_cs_n   = cs_n_q;
  assign adc_sclk   = sclk_q;
  assign Vout       = vout_q;
  assign clk_out    = clk_out_q;
  assign overrun    = overrun_q;

endmodule
